mac_swap_pipe: RTL



---
 rtl/mac_swap_pkg.sv | 16 +
 rtl/axis_skid_reg.sv | 47 ++++
 rtl/mac_swap_pipe.sv | 94 +++++++++
 3 files changed

// File: rtl/mac_swap_pkg.sv
// mac_swap_pkg: mode encoding, header byte offsets and helpers shared by the MAC swap pipeline.
package mac_swap_pkg;
  typedef enum logic [1:0] {PASS = 2'd0, MAC = 2'd1, MAC_IP = 2'd2, RSVD = 2'd3} swap_mode_e;
  localparam int MAC_DST_OFF = 0;
  localparam int MAC_SRC_OFF = 6;
  localparam int ETYPE_OFF = 12;
  localparam int IP_SRC_OFF = 26;
  localparam int IP_DST_OFF = 30;
  localparam int MAC_W = 48;
  localparam int IP_W = 32;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  // Header fields are big-endian on the wire while byte 0 sits in the low tdata bits.
  function automatic logic [15:0] wire_order16(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction
endpackage

// File: rtl/axis_skid_reg.sv
// axis_skid_reg: 2-entry AXI4-Stream register slice with registered ready for full throughput.
module axis_skid_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data
);
  logic main_valid_q, main_valid_d, skid_valid_q, skid_valid_d, rdy_q, rdy_d;
  logic [W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic acc, pop, to_skid;
  always_comb begin
    acc = s_valid && rdy_q;
    pop = main_valid_q && m_ready;
    to_skid = !skid_valid_q && acc && main_valid_q && !pop;
    main_valid_d = skid_valid_q || acc || (main_valid_q && !pop);
    main_data_d = skid_valid_q ? (pop ? skid_data_q : main_data_q)
                               : ((acc && (!main_valid_q || pop)) ? s_data : main_data_q);
    skid_valid_d = skid_valid_q ? !pop : to_skid;
    skid_data_d = to_skid ? s_data : skid_data_q;
    rdy_d = !skid_valid_d;
  end
  // Ready is held low through reset and comes up on the first clock after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      rdy_q <= 1'b0;
      main_data_q <= '0;
      skid_data_q <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      rdy_q <= rdy_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
    end
  end
  assign s_ready = rdy_q;
  assign m_valid = main_valid_q;
  assign m_data = main_data_q;
endmodule

// File: rtl/mac_swap_pipe.sv
// mac_swap_pipe: per-channel first-beat MAC/IPv4 address swap with skid-buffered output and packet counters.
module mac_swap_pipe
  import mac_swap_pkg::*;
#(
  parameter int NUM_CH = 1,
  parameter int DATA_W = 512,
  parameter int USER_W = 16
) (
  input  logic                         axis_aclk,
  input  logic                         axis_rst,
  input  logic [2*NUM_CH-1:0]          mode,
  input  logic [NUM_CH-1:0]            s_axis_tvalid,
  input  logic [NUM_CH-1:0]            s_axis_tlast,
  output logic [NUM_CH-1:0]            s_axis_tready,
  input  logic [DATA_W*NUM_CH-1:0]     s_axis_tdata,
  input  logic [DATA_W/8*NUM_CH-1:0]   s_axis_tkeep,
  input  logic [USER_W*NUM_CH-1:0]     s_axis_tuser_size,
  input  logic [USER_W*NUM_CH-1:0]     s_axis_tuser_src,
  input  logic [USER_W*NUM_CH-1:0]     s_axis_tuser_dst,
  output logic [NUM_CH-1:0]            m_axis_tvalid,
  output logic [NUM_CH-1:0]            m_axis_tlast,
  input  logic [NUM_CH-1:0]            m_axis_tready,
  output logic [DATA_W*NUM_CH-1:0]     m_axis_tdata,
  output logic [DATA_W/8*NUM_CH-1:0]   m_axis_tkeep,
  output logic [USER_W*NUM_CH-1:0]     m_axis_tuser_size,
  output logic [USER_W*NUM_CH-1:0]     m_axis_tuser_src,
  output logic [USER_W*NUM_CH-1:0]     m_axis_tuser_dst,
  output logic [32*NUM_CH-1:0]         pkt_cnt,
  output logic [32*NUM_CH-1:0]         swap_cnt
);
  localparam int KEEP_W = DATA_W / 8;
  localparam int PAY_W = 1 + 3 * USER_W + 1 + KEEP_W + DATA_W;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic in_pkt_q, in_pkt_d, first, do_mac, do_ip, acc, pop, m_sw;
    swap_mode_e pkt_mode_q, pkt_mode_d, raw_mode, smode, cur_mode;
    logic [31:0] pkt_cnt_q, pkt_cnt_d, swap_cnt_q, swap_cnt_d;
    logic [DATA_W-1:0] din, dout;
    logic [PAY_W-1:0] s_pay, m_pay;
    always_comb begin
      din = s_axis_tdata[c*DATA_W +: DATA_W];
      first = !in_pkt_q;
      raw_mode = swap_mode_e'(mode[2*c +: 2]);
      smode = (raw_mode == RSVD) ? PASS : raw_mode;
      cur_mode = first ? smode : pkt_mode_q;
      do_mac = first && (cur_mode == MAC || cur_mode == MAC_IP);
      do_ip = do_mac && cur_mode == MAC_IP && din[ETYPE_OFF*8 +: 16] == wire_order16(ETHERTYPE_IPV4);
      dout = din;
      if (do_mac) begin
        dout[MAC_DST_OFF*8 +: MAC_W] = din[MAC_SRC_OFF*8 +: MAC_W];
        dout[MAC_SRC_OFF*8 +: MAC_W] = din[MAC_DST_OFF*8 +: MAC_W];
      end
      if (do_ip) begin
        dout[IP_SRC_OFF*8 +: IP_W] = din[IP_DST_OFF*8 +: IP_W];
        dout[IP_DST_OFF*8 +: IP_W] = din[IP_SRC_OFF*8 +: IP_W];
      end
      s_pay = {do_mac, s_axis_tuser_dst[c*USER_W +: USER_W], s_axis_tuser_src[c*USER_W +: USER_W],
               s_axis_tuser_size[c*USER_W +: USER_W], s_axis_tlast[c], s_axis_tkeep[c*KEEP_W +: KEEP_W], dout};
      acc = s_axis_tvalid[c] && s_axis_tready[c];
      in_pkt_d = acc ? !s_axis_tlast[c] : in_pkt_q;
      pkt_mode_d = (acc && first) ? smode : pkt_mode_q;
      pop = m_axis_tvalid[c] && m_axis_tready[c];
      pkt_cnt_d = pkt_cnt_q + 32'(pop && m_axis_tlast[c]);
      swap_cnt_d = swap_cnt_q + 32'(pop && m_sw);
    end
    always_ff @(posedge axis_aclk or posedge axis_rst) begin
      if (axis_rst) begin
        in_pkt_q <= 1'b0;
        pkt_mode_q <= PASS;
        pkt_cnt_q <= '0;
        swap_cnt_q <= '0;
      end else begin
        in_pkt_q <= in_pkt_d;
        pkt_mode_q <= pkt_mode_d;
        pkt_cnt_q <= pkt_cnt_d;
        swap_cnt_q <= swap_cnt_d;
      end
    end
    axis_skid_reg #(.W(PAY_W)) u_skid (
      .clk     (axis_aclk),
      .rst     (axis_rst),
      .s_valid (s_axis_tvalid[c]),
      .s_ready (s_axis_tready[c]),
      .s_data  (s_pay),
      .m_valid (m_axis_tvalid[c]),
      .m_ready (m_axis_tready[c]),
      .m_data  (m_pay)
    );
    assign {m_sw, m_axis_tuser_dst[c*USER_W +: USER_W], m_axis_tuser_src[c*USER_W +: USER_W],
            m_axis_tuser_size[c*USER_W +: USER_W], m_axis_tlast[c], m_axis_tkeep[c*KEEP_W +: KEEP_W],
            m_axis_tdata[c*DATA_W +: DATA_W]} = m_pay;
    assign pkt_cnt[c*32 +: 32] = pkt_cnt_q;
    assign swap_cnt[c*32 +: 32] = swap_cnt_q;
  end
endmodule
